tristate_bus_arbiter: RTL
=========================

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one requester may own the bus (legal range 1-255).
REQ-002 Parameter TURN_CYC, default 1: bus-off turnaround cycles between owners (legal range 1-15).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  8  per-source bus request; requester k holds req[k] high while it needs the bus.
REQ-006 gnt  output 8  one-hot grant; at most one bit high.
REQ-007 sel  output 3  binary index of the granted source, driving the 8:1 tri-state mux select lines.
REQ-008 drv_en  output 1  tri-state driver enable; high only while a grant is active.
REQ-009 busy  output 1  high in any state other than IDLE.
REQ-010 timeout  output 1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Function
REQ-011 The FSM SHALL have three states: IDLE, OWN, TURN.
REQ-012 IDLE: gnt=0, drv_en=0; if any req bit is high, the winner SHALL be registered and the state SHALL move to OWN on the next edge, giving 1-cycle req-to-gnt latency.
REQ-013 Winner selection SHALL be round-robin: search starts at index ptr, then ascends modulo 8, so 7 wraps to 0.
REQ-014 On entry to OWN, ptr SHALL be set to (winner+1) mod 8.
REQ-015 OWN: gnt[owner]=1, sel=owner, drv_en=1; a hold counter SHALL count cycles in OWN starting at 1.
REQ-016 OWN SHALL exit to TURN when req[owner]=0 or when the hold counter equals MAX_HOLD.
REQ-017 timeout SHALL pulse for one cycle, coincident with the first TURN cycle, only if req[owner] was still high at expiry.
REQ-018 If req[owner] drops on the same cycle the hold counter reaches MAX_HOLD, the exit SHALL be a normal release and timeout SHALL stay 0.
REQ-019 TURN: gnt=0, drv_en=0, sel SHALL hold the last owner; after TURN_CYC cycles, the state SHALL go to OWN with a new winner if any req is high, else to IDLE.
REQ-020 Requests arriving during TURN SHALL be sampled on the last TURN cycle only.
REQ-021 A previous owner re-requesting SHALL be arbitrated normally, and through the ptr rule it has lowest priority.
REQ-022 drv_en and gnt SHALL be registered outputs, glitch-free, and SHALL never both be active for two different sources in the same cycle.
REQ-023 Requests from non-owners during OWN SHALL have no effect until TURN completes.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, gnt=0, sel=0, drv_en=0, busy=0, timeout=0, ptr=0 and counters=0, including in the middle of OWN or TURN.
REQ-025 After rst deasserts, the first arbitration SHALL give priority to source 0.

Structure
REQ-026 State encodings, source count (8) and select width (3) SHALL live in the shared mux-bus package/header, reused by the tri-state mux wrappers.
REQ-027 The round-robin priority search SHALL be one sub-module, rr_pick8, which is purely combinational: inputs are req and ptr, outputs are a valid flag and a 3-bit index.
REQ-028 The arbiter outputs sel and drv_en SHALL connect directly to the 8:1 tri-state mux select lines and the mux output-enable gating.

Verification
REQ-029 Reset state, then req=8'h00 for 5 cycles: gnt=0, drv_en=0, busy=0 throughout.
REQ-030 req=8'h81 from reset: gnt=8'h01 one cycle later; drop req[0] after 3 cycles, then TURN for 1 cycle, then gnt=8'h80 and sel=7.
REQ-031 req=8'h80 held with MAX_HOLD=4: gnt=8'h80 for exactly 4 cycles, timeout pulse, 1 TURN cycle, then gnt=8'h80 again because it is the only requester.
REQ-032 req=8'hFF held, owners releasing after 2 cycles each: grant order 0,1,...,7,0, with wrap-around 7 to 0 checked, and drv_en low exactly TURN_CYC cycles between each pair of owners.
REQ-033 req[3] drops on the same cycle as MAX_HOLD expiry: TURN entered, timeout stays 0.
REQ-034 Assert rst in the middle of OWN with gnt=8'h10: gnt, drv_en and busy go to 0 before the next clock edge; after release with req=8'h11, the first grant is 8'h01.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared mux-bus definitions: source count, select width and arbiter state encoding.
// The tri-state mux wrappers import the same package, so bus width and select width stay in one place.
package tristate_bus_arbiter_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

    function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return {{(N_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping 7 -> 0.
module rr_pick8
    import tristate_bus_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets high to low so the smallest offset from ptr is the last one to win.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared 8-source tri-state bus with hold limit and turnaround.
// sel and drv_en go straight to the 8:1 mux select lines and output-enable gating.
//
// state | meaning
// IDLE  | bus undriven, arbitrating every cycle
// OWN   | one source granted, drivers enabled, hold counter running
// TURN  | drivers off for TURN_CYC cycles, sel holds last owner
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             drv_en,
    output logic             busy,
    output logic             timeout
);

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [3:0]       turn_cnt;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             arb_slot;
    logic             own_done;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Requests are only looked at in IDLE and on the final TURN cycle.
    assign arb_slot = (state == ST_IDLE) || (state == ST_TURN && turn_cnt == 4'd0);
    assign own_done = !req[sel] || (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            drv_en   <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= 8'd0;
            turn_cnt <= 4'd0;
        end else begin
            timeout <= 1'b0;
            if (arb_slot && pick_valid) begin
                state    <= ST_OWN;
                gnt      <= idx_to_onehot(pick_idx);
                sel      <= pick_idx;
                ptr      <= pick_idx + SEL_W'(1);
                drv_en   <= 1'b1;
                busy     <= 1'b1;
                hold_cnt <= 8'd1;
            end else if (arb_slot) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (state == ST_TURN) begin
                turn_cnt <= turn_cnt - 4'd1;
            end else if (state == ST_OWN) begin
                if (own_done) begin
                    state    <= ST_TURN;
                    gnt      <= '0;
                    drv_en   <= 1'b0;
                    turn_cnt <= TURN_LOAD;
                    hold_cnt <= 8'd0;
                    // A dropped request wins over expiry, so req still high here means forced release.
                    timeout  <= req[sel];
                end else begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else begin
                state  <= ST_IDLE;
                gnt    <= '0;
                drv_en <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

endmodule
